// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction FIFO between fetch (IF) and decode (ID).
// Optional macro FETCH_BUFFER_BYPASS_EN: when empty, a presented instruction
// is shown on the output in the same cycle (and not stored if consumed).
// Entry storage is not reset; only pointers, occupancy and the run flag are.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [DEPTH-1:0][XLEN-1:0] pc_mem;
  logic [DEPTH-1:0][XLEN-1:0] instr_mem;
  logic [PW-1:0]              rd_ptr, wr_ptr;
  logic                       run;     // low in reset, high from the first edge after release
  logic                       empty, full, bypass;
  logic                       push, pop, store, take;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass = run && empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // in_ready never looks at out_ready: a full buffer takes nothing until a pop has landed
  assign in_ready  = run && !full && !flush;
  assign out_valid = run && !flush && (!empty || bypass);

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  // a bypassed instruction that is consumed immediately never occupies an entry
  assign store = push && !(bypass && out_ready);
  // pops only drain storage when there is something stored
  assign take  = pop && !empty;

  // Head presentation: NOP/zero when nothing is valid
  always_comb begin
    out_pc    = '0;
    out_instr = NOP;
    if (out_valid) begin
`ifdef FETCH_BUFFER_BYPASS_EN
      if (bypass) begin
        out_pc    = in_pc;
        out_instr = in_instr;
      end else begin
        out_pc    = pc_mem[rd_ptr];
        out_instr = instr_mem[rd_ptr];
      end
`else
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
`endif
    end
  end

  // Pointers and occupancy; flush wins over any push/pop in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run    <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (store) wr_ptr <= wr_ptr + 1'b1;  // wraps modulo DEPTH (power of two)
        if (take)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(store) - CW'(take);
      end
    end
  end

  // Entry storage, written without reset
  always_ff @(posedge clk) begin
    if (store) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed + random stimulus against a queue-based model.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, flush;
  logic [XLEN-1:0] in_pc, in_instr, out_pc, out_instr;
  logic [2:0]      count;

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: ordered list of stored {pc, instr} plus a "running" flag
  logic [63:0] q[$];
  bit          alive = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // one clock cycle: drive, check combinational outputs, advance model across the edge
  task automatic cyc(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                     input bit ordy, input bit fl, output bit accepted);
    bit e_ir, e_ov, byp;
    logic [31:0] e_pc, e_in;
    in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    #1;
    e_ir = alive && (q.size() < DEPTH) && !fl;
    byp  = BYP && alive && (q.size() == 0) && iv && !fl;
    e_ov = alive && !fl && (q.size() != 0 || byp);
    if (!e_ov)             begin e_pc = 0;          e_in = NOP; end
    else if (q.size() != 0) begin e_pc = q[0][63:32]; e_in = q[0][31:0]; end
    else                   begin e_pc = pc;         e_in = ins; end
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("out_pc", out_pc, e_pc);
    chk("out_instr", out_instr, e_in);
    accepted = iv && e_ir;
    if (fl) q.delete();
    else begin
      if (e_ov && ordy && q.size() != 0) void'(q.pop_front());
      if (accepted && !(byp && ordy)) q.push_back({pc, ins});
    end
    @(posedge clk); #1;
    alive = rst;
  endtask

  task automatic idle(input bit ordy);
    bit a;
    cyc(1'b0, 32'h0, 32'h0, ordy, 1'b0, a);
  endtask

  initial begin
    bit a;
    int idx, guard;
    rst = 1'b0; in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0; flush = 0;
    #2;
    // reset state, no clock edge needed
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, NOP);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1'b0);                         // first edge after release: ready rises
    chk("ready_after_rst", 32'(in_ready), 1);

    // three pushes, no pops
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(i*4), $urandom, 1'b0, 1'b0, a);
    idle(1'b0);
    chk("three_count", 32'(count), 3);
    chk("three_head", out_pc, 32'h0);

    // fill to DEPTH, 5th held until a pop lands
    cyc(1'b1, 32'hC, $urandom, 1'b0, 1'b0, a);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h10, 32'hAAAA_0010, 1'b0, 1'b0, a);
    chk("full_held", 32'(a), 0);
    cyc(1'b1, 32'h10, 32'hAAAA_0010, 1'b1, 1'b0, a);   // pop; still full this cycle
    chk("held_at_pop", 32'(a), 0);
    cyc(1'b1, 32'h10, 32'hAAAA_0010, 1'b0, 1'b0, a);
    chk("fifth_accepted", 32'(a), 1);

    // drain to 2, then simultaneous push/pop
    cyc(1'b0, 0, 0, 1'b1, 1'b0, a);
    cyc(1'b0, 0, 0, 1'b1, 1'b0, a);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h100 + 32'(i*4), $urandom, 1'b1, 1'b0, a);
    chk("simul_count", 32'(count), 2);
    repeat (3) idle(1'b1);

    // flush at count 3 with a push present
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(i*4), $urandom, 1'b0, 1'b0, a);
    cyc(1'b1, 32'hDEAD, 32'hDEAD_BEEF, 1'b1, 1'b1, a);
    idle(1'b0);
    chk("flush_count", 32'(count), 0);
    chk("flush_instr", out_instr, NOP);
    cyc(1'b1, 32'h300, 32'h1234_5678, 1'b0, 1'b0, a);
    idle(1'b1);                         // head must be 0x300, not the flushed 0xDEAD
    idle(1'b1);

    // stream 10 instructions with toggling out_ready across pointer wrap
    idx = 0; guard = 0;
    while (idx < 10 && guard < 200) begin
      cyc(1'b1, 32'(idx*4), 32'hC0DE_0000 | 32'(idx), guard[0], 1'b0, a);
      if (a) idx++;
      guard++;
    end
    chk("stream_done", 32'(idx), 10);
    guard = 0;
    while (q.size() != 0 && guard < 50) begin idle(1'b1); guard++; end
    chk("stream_drained", 32'(count), 0);

    // async reset mid-stream at count 2
    cyc(1'b1, 32'h500, $urandom, 1'b0, 1'b0, a);
    cyc(1'b1, 32'h504, $urandom, 1'b0, 1'b0, a);
    rst = 1'b0; #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    q.delete(); alive = 1'b0;
    #1 rst = 1'b1;
    idle(1'b0);

    // bypass scenario: empty, push 0x40 with out_ready=1
    cyc(1'b1, 32'h40, 32'h0000_0040, 1'b1, 1'b0, a);
    chk("byp_count_after", 32'(count), BYP ? 0 : 1);
    chk("byp_next_valid", 32'(out_valid), BYP ? 0 : 1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom), $urandom, $urandom, 1'($urandom), ($urandom_range(0, 19) == 0), a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of instruction entries; it SHALL be a power of two and at least 2.
REQ-002 The module SHALL have parameter XLEN, default 32, giving the PC and instruction width.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  the IF stage presents a fetched instruction.
REQ-006 Port in_ready  output  1  the buffer accepts the presented instruction this cycle.
REQ-007 Port in_pc  input  XLEN  PC of the presented instruction.
REQ-008 Port in_instr  input  XLEN  instruction word.
REQ-009 Port out_valid  output  1  the head entry is valid for the ID stage.
REQ-010 Port out_ready  input  1  the ID stage consumes the head this cycle.
REQ-011 Port out_pc  output  XLEN  PC of the head entry.
REQ-012 Port out_instr  output  XLEN  instruction word of the head entry.
REQ-013 Port flush  input  1  branch/jump redirect; discards all buffered instructions.
REQ-014 Port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 The block SHALL be a FIFO between instruction fetch and decode, preserving PC order.
REQ-016 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL be (count < DEPTH) && !flush; it SHALL NOT depend on out_ready, so there is no pass-through when the buffer is full.
REQ-018 out_valid SHALL be (count != 0) && !flush; out_pc and out_instr SHALL show the head entry.
REQ-019 When out_valid=0, out_pc SHALL be 0 and out_instr SHALL be 32'h00000013 (NOP).
REQ-020 The read and write pointers SHALL wrap modulo DEPTH.
REQ-021 count SHALL update as +1 on a push only, -1 on a pop only, and stay unchanged on a simultaneous push and pop.
REQ-022 Without bypass, the latency from push to out_valid SHALL be exactly 1 cycle.
REQ-023 flush SHALL have top priority: the next edge sets count and both pointers to 0, and any push or pop in the flush cycle is ignored.
REQ-024 At count=DEPTH with in_valid=1, the entry SHALL be held (in_ready=0) until a pop; in_ready SHALL rise on the cycle after that pop.
REQ-025 At count=0, out_ready SHALL have no effect.

Reset
REQ-026 While rst=0, the block SHALL immediately set count=0, both pointers=0, in_ready=0, out_valid=0, out_pc=0, out_instr=32'h00000013, regardless of the clock.
REQ-027 Entry storage SHALL NOT require reset.
REQ-028 On the first edge after rst releases, in_ready SHALL be 1.

Configuration
REQ-029 Macro FETCH_BUFFER_BYPASS_EN SHALL control bypass.
- Defined: when count=0 and in_valid=1 and flush=0, out_valid=1 in the same cycle, with out_pc=in_pc and out_instr=in_instr. If out_ready=1, nothing is stored and count stays 0. If out_ready=0, the entry is stored normally.
- Undefined: REQ-022 applies and no combinational path from in_* to out_* exists.

Verification
REQ-030 The bench SHALL cover the following scenarios:
- Push at PCs 0x0, 0x4, 0x8 with out_ready=0 -> count=3, out_valid=1, out_pc=0x0.
- Push 5 entries with DEPTH=4 -> in_ready=0 at count=4 and the 5th is held; one pop -> in_ready=1 the next cycle and the 5th is accepted with correct order.
- Simultaneous push and pop at count=2 -> count stays 2, and pops return PCs in push order.
- flush with count=3 and in_valid=1 -> next cycle count=0 and out_valid=0, out_instr=0x00000013, and the flushed push never appears.
- Stream 10 instructions through (PCs 0x0..0x24) with out_ready toggling -> outputs in exact order across pointer wrap; rst=0 mid-stream with count=2 -> count=0 before the next edge.
- Bypass: with FETCH_BUFFER_BYPASS_EN, count=0, in_valid=1, out_ready=1, in_pc=0x40 -> out_valid=1 and out_pc=0x40 the same cycle, count stays 0; without the macro -> out_valid=1 one cycle later.
